// File: rtl/tpu_uart_pkg.sv
// Shared definitions for the host UART command front end: opcodes, FSM encodings, payload sizes.
package tpu_uart_pkg;

    localparam logic [7:0] CMD_LOAD_W   = 8'h01;
    localparam logic [7:0] CMD_LOAD_ACT = 8'h02;
    localparam logic [7:0] CMD_START    = 8'h03;
    localparam logic [7:0] CMD_RESET_W  = 8'h04;
    localparam logic [7:0] CMD_STATUS   = 8'h05;
    localparam logic [7:0] CMD_READ_ACC = 8'h06;

    localparam int unsigned NUM_WEIGHT_BYTES = 4;
    localparam int unsigned NUM_ACT_BYTES    = 2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RECV_W    = 4'd1,
        ST_RECV_ACT  = 4'd2,
        ST_EXEC      = 4'd3,
        ST_RESP_SEND = 4'd4,
        ST_RESP_WAIT = 4'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_serdes.sv
// UART 8N1 receiver and transmitter with a byte-wide rx_valid and tx_valid/tx_ready interface.
module uart_serdes
    import tpu_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta, rx_s, rx_prev;
    rx_state_t        rx_state, rx_state_d;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]       rx_bit, rx_bit_d;
    logic [7:0]       rx_shift, rx_shift_d, rx_data_d;
    logic             rx_valid_d;

    tx_state_t        tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
    logic [3:0]       tx_bit, tx_bit_d;
    logic [8:0]       tx_shift, tx_shift_d;
    logic             uart_tx_d, tx_ready_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            uart_tx  <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            rx_meta  <= uart_rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            rx_valid <= rx_valid_d;
            rx_data  <= rx_data_d;
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            uart_tx  <= uart_tx_d;
            tx_ready <= tx_ready_d;
        end
    end

    // Receiver: only a falling edge starts a frame, so a line held low after a bad stop is ignored.
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = CNT_W'(rx_cnt + 1'b1);
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift[7:1]};
                    rx_bit_d   = 3'(rx_bit + 3'd1);
                    if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Transmitter: shift register holds data plus stop bit; start bit is driven on acceptance.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = CNT_W'(tx_cnt + 1'b1);
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        uart_tx_d  = uart_tx;
        tx_ready_d = tx_ready;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d   = '0;
                tx_ready_d = 1'b1;
                uart_tx_d  = 1'b1;
                if (tx_valid && tx_ready) begin
                    tx_state_d = TX_BUSY;
                    uart_tx_d  = 1'b0;
                    tx_shift_d = {1'b1, tx_data};
                    tx_bit_d   = '0;
                    tx_ready_d = 1'b0;
                end
            end
            TX_BUSY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        tx_ready_d = 1'b1;
                    end else begin
                        uart_tx_d  = tx_shift[0];
                        tx_shift_d = {1'b1, tx_shift[8:1]};
                        tx_bit_d   = 4'(tx_bit + 4'd1);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_controller.sv
// Host command front end: decodes UART byte streams into weight/activation loads, MLP start
// and status/accumulator readback.
module uart_cmd_controller
    import tpu_uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rx,
    output logic               uart_tx,
    output logic               wf_push_col0,
    output logic               wf_push_col1,
    output logic [7:0]         wf_data_in,
    output logic               wf_reset,
    output logic               init_act_valid,
    output logic [15:0]        init_act_data,
    output logic               start_mlp,
    output logic               weights_ready,
    input  logic [2:0]         mlp_state,
    input  logic [4:0]         mlp_cycle_cnt,
    input  logic signed [31:0] mlp_acc0,
    output logic [3:0]         dbg_state,
    output logic [7:0]         dbg_cmd_reg,
    output logic [2:0]         dbg_byte_count,
    output logic [1:0]         dbg_resp_byte_idx,
    output logic               dbg_tx_valid,
    output logic               dbg_tx_ready,
    output logic               dbg_rx_valid,
    output logic               dbg_weights_ready,
    output logic               dbg_start_mlp
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

    ctrl_state_t state, state_d;
    logic [7:0]  cmd_reg, cmd_d;
    logic [2:0]  byte_count, byte_count_d;
    logic [1:0]  resp_idx, resp_idx_d, resp_last_c;
    logic [31:0] snap, snap_d;
    logic        push0_d, push1_d, wf_reset_d, act_valid_d, start_d, wready_d;
    logic [7:0]  wf_data_d;
    logic [15:0] act_data_d;
    logic        rx_valid, tx_ready, tx_valid_c;
    logic [7:0]  rx_data, tx_byte_c;

    uart_serdes #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_serdes (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid_c),
        .tx_data  (tx_byte_c),
        .tx_ready (tx_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cmd_reg        <= '0;
            byte_count     <= '0;
            resp_idx       <= '0;
            snap           <= '0;
            wf_push_col0   <= 1'b0;
            wf_push_col1   <= 1'b0;
            wf_data_in     <= '0;
            wf_reset       <= 1'b0;
            init_act_valid <= 1'b0;
            init_act_data  <= '0;
            start_mlp      <= 1'b0;
            weights_ready  <= 1'b0;
            dbg_tx_valid   <= 1'b0;
            dbg_tx_ready   <= 1'b0;
            dbg_rx_valid   <= 1'b0;
        end else begin
            state          <= state_d;
            cmd_reg        <= cmd_d;
            byte_count     <= byte_count_d;
            resp_idx       <= resp_idx_d;
            snap           <= snap_d;
            wf_push_col0   <= push0_d;
            wf_push_col1   <= push1_d;
            wf_data_in     <= wf_data_d;
            wf_reset       <= wf_reset_d;
            init_act_valid <= act_valid_d;
            init_act_data  <= act_data_d;
            start_mlp      <= start_d;
            weights_ready  <= wready_d;
            dbg_tx_valid   <= tx_valid_c;
            dbg_tx_ready   <= tx_ready;
            dbg_rx_valid   <= rx_valid;
        end
    end

    assign dbg_state         = state;
    assign dbg_cmd_reg       = cmd_reg;
    assign dbg_byte_count    = byte_count;
    assign dbg_resp_byte_idx = resp_idx;
    assign dbg_weights_ready = weights_ready;
    assign dbg_start_mlp     = start_mlp;

    // Command FSM; STATUS also goes through the snapshot so both responses share one byte path.
    always_comb begin
        state_d      = state;
        cmd_d        = cmd_reg;
        byte_count_d = byte_count;
        resp_idx_d   = resp_idx;
        snap_d       = snap;
        push0_d      = 1'b0;
        push1_d      = 1'b0;
        wf_reset_d   = 1'b0;
        act_valid_d  = 1'b0;
        start_d      = 1'b0;
        wready_d     = weights_ready;
        wf_data_d    = wf_data_in;
        act_data_d   = init_act_data;
        tx_valid_c   = 1'b0;
        resp_last_c  = (cmd_reg == CMD_STATUS) ? 2'd0 : 2'd3;
        tx_byte_c    = 8'(snap >> {resp_idx, 3'b000});
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    cmd_d = rx_data;
                    case (rx_data)
                        CMD_LOAD_W: begin
                            state_d      = ST_RECV_W;
                            byte_count_d = '0;
                        end
                        CMD_LOAD_ACT: begin
                            state_d      = ST_RECV_ACT;
                            byte_count_d = '0;
                        end
                        CMD_START: begin
                            state_d = ST_EXEC;
                            start_d = weights_ready && (mlp_state == 3'd0);
                        end
                        CMD_RESET_W: begin
                            state_d    = ST_EXEC;
                            wf_reset_d = 1'b1;
                            wready_d   = 1'b0;
                        end
                        CMD_STATUS: begin
                            state_d    = ST_RESP_SEND;
                            resp_idx_d = '0;
                            snap_d     = {24'd0, mlp_state, mlp_cycle_cnt};
                        end
                        CMD_READ_ACC: begin
                            state_d    = ST_RESP_SEND;
                            resp_idx_d = '0;
                            snap_d     = 32'(mlp_acc0);
                        end
                        default: ;
                    endcase
                end
            end
            ST_RECV_W: begin
                if (rx_valid) begin
                    wf_data_d    = rx_data;
                    byte_count_d = 3'(byte_count + 3'd1);
                    if (byte_count < 3'(NUM_WEIGHT_BYTES / 2)) push0_d = 1'b1;
                    else                                       push1_d = 1'b1;
                    if (byte_count == 3'(NUM_WEIGHT_BYTES - 1)) begin
                        wready_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_RECV_ACT: begin
                if (rx_valid) begin
                    byte_count_d = 3'(byte_count + 3'd1);
                    if (byte_count == 3'(NUM_ACT_BYTES - 1)) begin
                        act_data_d[15:8] = rx_data;
                        act_valid_d      = 1'b1;
                        state_d          = ST_IDLE;
                    end else begin
                        act_data_d[7:0] = rx_data;
                    end
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            ST_RESP_SEND: begin
                tx_valid_c = 1'b1;
                if (tx_ready) state_d = ST_RESP_WAIT;
            end
            ST_RESP_WAIT: begin
                if (tx_ready) begin
                    if (resp_idx == resp_last_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        resp_idx_d = 2'(resp_idx + 2'd1);
                        state_d    = ST_RESP_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed bench for uart_cmd_controller at 10 clocks per bit; a UART line model drives
// commands and decodes responses, monitors record pulses for the checks.
module tb_uart_cmd_controller;

    logic               clk;
    logic               rst;
    logic               uart_rx;
    logic               uart_tx;
    logic               wf_push_col0, wf_push_col1, wf_reset;
    logic [7:0]         wf_data_in;
    logic               init_act_valid;
    logic [15:0]        init_act_data;
    logic               start_mlp, weights_ready;
    logic [2:0]         mlp_state;
    logic [4:0]         mlp_cycle_cnt;
    logic signed [31:0] mlp_acc0;
    logic [3:0]         dbg_state;
    logic [7:0]         dbg_cmd_reg;
    logic [2:0]         dbg_byte_count;
    logic [1:0]         dbg_resp_byte_idx;
    logic               dbg_tx_valid, dbg_tx_ready, dbg_rx_valid;
    logic               dbg_weights_ready, dbg_start_mlp;

    uart_cmd_controller #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk               (clk),
        .rst               (rst),
        .uart_rx           (uart_rx),
        .uart_tx           (uart_tx),
        .wf_push_col0      (wf_push_col0),
        .wf_push_col1      (wf_push_col1),
        .wf_data_in        (wf_data_in),
        .wf_reset          (wf_reset),
        .init_act_valid    (init_act_valid),
        .init_act_data     (init_act_data),
        .start_mlp         (start_mlp),
        .weights_ready     (weights_ready),
        .mlp_state         (mlp_state),
        .mlp_cycle_cnt     (mlp_cycle_cnt),
        .mlp_acc0          (mlp_acc0),
        .dbg_state         (dbg_state),
        .dbg_cmd_reg       (dbg_cmd_reg),
        .dbg_byte_count    (dbg_byte_count),
        .dbg_resp_byte_idx (dbg_resp_byte_idx),
        .dbg_tx_valid      (dbg_tx_valid),
        .dbg_tx_ready      (dbg_tx_ready),
        .dbg_rx_valid      (dbg_rx_valid),
        .dbg_weights_ready (dbg_weights_ready),
        .dbg_start_mlp     (dbg_start_mlp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  q_col0[$];
    logic [7:0]  q_col1[$];
    logic [7:0]  q_tx[$];
    logic [15:0] act_data_seen = '0;
    int act_hi = 0, act_rise = 0, start_hi = 0, start_rise = 0, wrst_hi = 0, wrst_rise = 0;
    int rx_cnt = 0, rx_cyc = 0, tx_start_cyc = -1;
    logic act_prev = 1'b0, start_prev = 1'b0, wrst_prev = 1'b0;
    logic [7:0] tx_byte;

    // Pulse and push recorder
    always @(negedge clk) begin
        if (wf_push_col0) q_col0.push_back(wf_data_in);
        if (wf_push_col1) q_col1.push_back(wf_data_in);
        if (init_act_valid) begin
            act_hi++;
            act_data_seen = init_act_data;
        end
        if (init_act_valid && !act_prev) act_rise++;
        if (start_mlp) start_hi++;
        if (start_mlp && !start_prev) start_rise++;
        if (wf_reset) wrst_hi++;
        if (wf_reset && !wrst_prev) wrst_rise++;
        act_prev   = init_act_valid;
        start_prev = start_mlp;
        wrst_prev  = wf_reset;
        if (dbg_rx_valid) begin
            rx_cnt++;
            rx_cyc = cyc;
        end
    end

    // Serial decoder for the DUT transmit line, sampling mid-bit
    always begin
        @(negedge clk);
        if (rst && uart_tx == 1'b0) begin
            if (tx_start_cyc < 0) tx_start_cyc = cyc;
            repeat (5) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(negedge clk);
                tx_byte[i] = uart_tx;
            end
            repeat (10) @(negedge clk);
            if (uart_tx) q_tx.push_back(tx_byte);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx = stop;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && q_tx.size() < n; i++) @(negedge clk);
    endtask

    logic [15:0] v16;
    logic [31:0] v32;
    int          n_rx_before;

    initial begin
        rst           = 1'b0;
        uart_rx       = 1'b1;
        mlp_state     = 3'd0;
        mlp_cycle_cnt = 5'd0;
        mlp_acc0      = 32'sd0;
        repeat (5) @(negedge clk);

        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_pulses", 32'({wf_push_col0, wf_push_col1, wf_reset, init_act_valid, start_mlp}), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset_wready", 32'(weights_ready), 32'd0);
        check("reset_data", 32'({wf_data_in, init_act_data}), 32'd0);
        check("reset_cmd", 32'(dbg_cmd_reg), 32'd0);

        rst = 1'b1;
        repeat (3) @(negedge clk);

        // LOAD_W
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check("wready_before_4th", 32'(weights_ready), 32'd0);
        send_byte(8'h44, 1'b1);
        repeat (5) @(negedge clk);
        check("col0_count", 32'(q_col0.size()), 32'd2);
        check("col1_count", 32'(q_col1.size()), 32'd2);
        v16 = (q_col0.size() == 2) ? {q_col0[0], q_col0[1]} : 16'hxxxx;
        check("col0_data", 32'(v16), 32'h1122);
        v16 = (q_col1.size() == 2) ? {q_col1[0], q_col1[1]} : 16'hxxxx;
        check("col1_data", 32'(v16), 32'h3344);
        check("wready_after_4th", 32'(weights_ready), 32'd1);
        check("loadw_byte_count", 32'(dbg_byte_count), 32'd4);
        check("loadw_idle", 32'(dbg_state), 32'd0);

        // LOAD_ACT
        send_byte(8'h02, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h07, 1'b1);
        repeat (5) @(negedge clk);
        check("act_pulses", 32'(act_rise), 32'd1);
        check("act_width", 32'(act_hi), 32'd1);
        check("act_data", 32'(act_data_seen), 32'h0705);

        // START allowed, then blocked by a busy MLP
        send_byte(8'h03, 1'b1);
        repeat (5) @(negedge clk);
        check("start_pulses", 32'(start_rise), 32'd1);
        check("start_width", 32'(start_hi), 32'd1);
        mlp_state = 3'd2;
        send_byte(8'h03, 1'b1);
        repeat (5) @(negedge clk);
        check("start_busy_blocked", 32'(start_hi), 32'd1);
        mlp_state = 3'd0;

        // READ_ACC: value changed after decode must not leak into the response
        mlp_acc0     = -32'sd2;
        tx_start_cyc = -1;
        q_tx.delete();
        send_byte(8'h06, 1'b1);
        mlp_acc0 = 32'sh12345678;
        wait_tx(4, 600);
        check("acc_resp_count", 32'(q_tx.size()), 32'd4);
        v32 = (q_tx.size() == 4) ? {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} : 32'hxxxxxxxx;
        check("acc_resp_bytes", v32, 32'hFEFFFFFF);
        check("resp_latency_ok", 32'((tx_start_cyc >= rx_cyc) && (tx_start_cyc - rx_cyc <= 1)), 32'd1);
        repeat (20) @(negedge clk);
        check("acc_back_idle", 32'(dbg_state), 32'd0);

        // STATUS
        mlp_state     = 3'd3;
        mlp_cycle_cnt = 5'd9;
        q_tx.delete();
        send_byte(8'h05, 1'b1);
        wait_tx(1, 300);
        repeat (20) @(negedge clk);
        check("status_count", 32'(q_tx.size()), 32'd1);
        v16 = (q_tx.size() == 1) ? {8'h00, q_tx[0]} : 16'hxxxx;
        check("status_byte", 32'(v16), 32'h0069);
        check("status_idle", 32'(dbg_state), 32'd0);
        mlp_state     = 3'd0;
        mlp_cycle_cnt = 5'd0;

        // RESET_W then START guarded by weights_ready
        send_byte(8'h04, 1'b1);
        repeat (5) @(negedge clk);
        check("wreset_pulses", 32'(wrst_rise), 32'd1);
        check("wreset_width", 32'(wrst_hi), 32'd1);
        check("wready_cleared", 32'(weights_ready), 32'd0);
        send_byte(8'h03, 1'b1);
        repeat (5) @(negedge clk);
        check("start_unloaded_blocked", 32'(start_hi), 32'd1);

        // Unknown opcode
        send_byte(8'hAA, 1'b1);
        repeat (3) @(negedge clk);
        check("unknown_idle", 32'(dbg_state), 32'd0);
        check("unknown_cmd_reg", 32'(dbg_cmd_reg), 32'hAA);
        check("unknown_no_push", 32'(q_col0.size() + q_col1.size()), 32'd4);

        // Bad stop bit drops the byte; receiver recovers for the next frame
        n_rx_before = rx_cnt;
        send_byte(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        check("bad_stop_dropped", 32'(rx_cnt - n_rx_before), 32'd0);
        send_byte(8'hAB, 1'b1);
        repeat (3) @(negedge clk);
        check("rx_recovered", 32'(rx_cnt - n_rx_before), 32'd1);

        // Reset in the middle of a response
        mlp_acc0 = -32'sd2;
        send_byte(8'h06, 1'b1);
        for (int i = 0; i < 50 && uart_tx !== 1'b0; i++) @(negedge clk);
        check("tx_active_before_reset", 32'(uart_tx), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid_tx_high", 32'(uart_tx), 32'd1);
        check("reset_mid_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        check("post_reset_line_idle", 32'(uart_tx), 32'd1);
        q_tx.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
